rfile_mp: RTL and testbench

RFILE_MP -- requirements
Module: rfile_mp

---
 rtl/rfile_pkg.sv | 16 +
 rtl/rfile_scoreboard.sv | 78 +++++++
 rtl/rfile_mp.sv | 77 +++++++
 tb/tb_rfile_mp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfile_pkg.sv
// rfile_pkg -- shared constants and types for the multi-ported register file.
//   Def*      : default parameter values used by rfile_mp and rfile_scoreboard
//   data_t    : register word at the default data width
//   addr_t    : register index at the default address width
package rfile_pkg;

    localparam int DefDataWidth    = 32;
    localparam int DefAddressWidth = 5;
    localparam int DefNumRead      = 2;
    localparam int DefNumWrite     = 2;
    localparam int DefZeroReg      = 1;

    typedef logic [DefDataWidth-1:0]    data_t;
    typedef logic [DefAddressWidth-1:0] addr_t;

endpackage

// File: rtl/rfile_scoreboard.sv
// rfile_scoreboard -- one pending bit per register, tracking in-flight producers.
//   Clk, reset   : clock, synchronous active-low reset
//   RegR         : read addresses, used to report busyR
//   RFwrite/RegW : writeback enables/addresses, clear pending bits
//   issue/issueReg/issueReady : issue handshake, sets a pending bit when accepted
//   flush        : drops every pending bit, blocks issue this cycle
//   busyR        : per read port, register still has an outstanding producer
//   anyPending   : registered OR of all pending bits
module rfile_scoreboard
    import rfile_pkg::*;
#(
    parameter int AddressWidth = DefAddressWidth,
    parameter int NumRead      = DefNumRead,
    parameter int NumWrite     = DefNumWrite,
    parameter int ZeroReg      = DefZeroReg
) (
    input  logic                                 Clk,
    input  logic                                 reset,
    input  logic [NumRead-1:0][AddressWidth-1:0] RegR,
    output logic [NumRead-1:0]                   busyR,
    input  logic [NumWrite-1:0]                  RFwrite,
    input  logic [NumWrite-1:0][AddressWidth-1:0] RegW,
    input  logic                                 issue,
    input  logic [AddressWidth-1:0]              issueReg,
    output logic                                 issueReady,
    input  logic                                 flush,
    output logic                                 anyPending
);

    localparam int   Depth    = 1 << AddressWidth;
    localparam logic HardZero = (ZeroReg != 0);

    logic [Depth-1:0] pending;
    logic [Depth-1:0] pendingNext;
    logic [Depth-1:0] clearMask;
    logic [Depth-1:0] setMask;
    logic             issueZero;

    always_comb begin
        clearMask = '0;
        for (int i = 0; i < NumWrite; i++) begin
            if (RFwrite[i]) clearMask[RegW[i]] = 1'b1;
        end
    end

    // r0 never becomes pending, so issuing to it is always safe.
    assign issueZero  = HardZero && (issueReg == '0);
    assign issueReady = !flush && (!pending[issueReg] || clearMask[issueReg] || issueZero);

    always_comb begin
        setMask = '0;
        if (issue && issueReady && !issueZero) setMask[issueReg] = 1'b1;
    end

    // Set is applied after clear so a same-cycle writeback and re-issue
    // leaves the register owned by the new producer.
    always_comb begin
        pendingNext = '0;
        if (!flush) pendingNext = (pending & ~clearMask) | setMask;
        if (HardZero) pendingNext[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!reset) pending <= '0;
        else        pending <= pendingNext;
    end

    always_comb begin
        busyR = '0;
        for (int k = 0; k < NumRead; k++) begin
            busyR[k] = pending[RegR[k]] && !clearMask[RegR[k]]
                       && !(HardZero && (RegR[k] == '0));
        end
    end

    assign anyPending = |pending;

endmodule

// File: rtl/rfile_mp.sv
// rfile_mp -- multi-ported register file with write bypass and pending scoreboard.
//   Clk, reset          : clock, synchronous active-low reset
//   RegR/dataR/busyR    : combinational read ports with same-cycle write bypass
//   RFwrite/RegW/dataW  : write ports, higher index wins on address collision
//   issue/issueReg/issueReady, flush, anyPending : see rfile_scoreboard
module rfile_mp
    import rfile_pkg::*;
#(
    parameter int dataWidth    = DefDataWidth,
    parameter int AddressWidth = DefAddressWidth,
    parameter int NumRead      = DefNumRead,
    parameter int NumWrite     = DefNumWrite,
    parameter int ZeroReg      = DefZeroReg
) (
    input  logic                                  Clk,
    input  logic                                  reset,
    input  logic [NumRead-1:0][AddressWidth-1:0]  RegR,
    output logic [NumRead-1:0][dataWidth-1:0]     dataR,
    output logic [NumRead-1:0]                    busyR,
    input  logic [NumWrite-1:0]                   RFwrite,
    input  logic [NumWrite-1:0][AddressWidth-1:0] RegW,
    input  logic [NumWrite-1:0][dataWidth-1:0]    dataW,
    input  logic                                  issue,
    input  logic [AddressWidth-1:0]               issueReg,
    output logic                                  issueReady,
    input  logic                                  flush,
    output logic                                  anyPending
);

    localparam int   Depth    = 1 << AddressWidth;
    localparam logic HardZero = (ZeroReg != 0);

    logic [dataWidth-1:0] regs [Depth];

    // Later loop iterations override earlier ones, giving the higher port priority.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            for (int r = 0; r < Depth; r++) regs[r] <= '0;
        end else begin
            for (int i = 0; i < NumWrite; i++) begin
                if (RFwrite[i] && !(HardZero && (RegW[i] == '0))) regs[RegW[i]] <= dataW[i];
            end
        end
    end

    // Bypass scans ports in ascending order so the same priority applies as storage.
    always_comb begin
        dataR = '0;
        for (int k = 0; k < NumRead; k++) begin
            dataR[k] = regs[RegR[k]];
            for (int i = 0; i < NumWrite; i++) begin
                if (RFwrite[i] && (RegW[i] == RegR[k])) dataR[k] = dataW[i];
            end
            if (HardZero && (RegR[k] == '0)) dataR[k] = '0;
        end
    end

    rfile_scoreboard #(
        .AddressWidth(AddressWidth),
        .NumRead     (NumRead),
        .NumWrite    (NumWrite),
        .ZeroReg     (ZeroReg)
    ) uScoreboard (
        .Clk       (Clk),
        .reset     (reset),
        .RegR      (RegR),
        .busyR     (busyR),
        .RFwrite   (RFwrite),
        .RegW      (RegW),
        .issue     (issue),
        .issueReg  (issueReg),
        .issueReady(issueReady),
        .flush     (flush),
        .anyPending(anyPending)
    );

endmodule

// File: tb/tb_rfile_mp.sv
module tb_rfile_mp;

    logic             Clk;
    logic             reset;
    logic [1:0][4:0]  RegR;
    logic [1:0][31:0] dataR;
    logic [1:0]       busyR;
    logic [1:0]       RFwrite;
    logic [1:0][4:0]  RegW;
    logic [1:0][31:0] dataW;
    logic             issue;
    logic [4:0]       issueReg;
    logic             issueReady;
    logic             flush;
    logic             anyPending;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        expQ[$];
    exp_t        e;
    logic [31:0] act;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [32];

    rfile_mp #(
        .dataWidth(32), .AddressWidth(5), .NumRead(2), .NumWrite(2), .ZeroReg(1)
    ) dut (
        .Clk(Clk), .reset(reset), .RegR(RegR), .dataR(dataR), .busyR(busyR),
        .RFwrite(RFwrite), .RegW(RegW), .dataW(dataW), .issue(issue),
        .issueReg(issueReg), .issueReady(issueReady), .flush(flush),
        .anyPending(anyPending)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void push(input string n, input int s, input logic [31:0] v);
        exp_t x;
        x.name = n; x.sel = s; x.val = v;
        expQ.push_back(x);
    endfunction

    function automatic logic [31:0] observe(input int s);
        case (s)
            0:       return dataR[0];
            1:       return dataR[1];
            2:       return {31'd0, busyR[0]};
            3:       return {31'd0, busyR[1]};
            4:       return {31'd0, issueReady};
            default: return {31'd0, anyPending};
        endcase
    endfunction

    task automatic idle();
        reset = 1'b1; RFwrite = '0; RegW = '0; dataW = '0;
        issue = 1'b0; issueReg = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); RegR = '0; reset = 1'b0;
        step(); step();
        reset = 1'b1; RegR[0] = 5'd3; RegR[1] = 5'd4; issueReg = 5'd9;
        push("rst_dataR0", 0, 32'h0); push("rst_dataR1", 1, 32'h0);
        push("rst_busyR0", 2, 32'h0); push("rst_issueReady", 4, 32'h1);
        push("rst_anyPending", 5, 32'h0);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
    endtask

    task automatic test_bypass();
        step(); idle();
        RFwrite[0] = 1'b1; RegW[0] = 5'd2; dataW[0] = 32'h3; RegR[0] = 5'd2;
        push("bypass_same_cycle", 0, 32'h3);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        step(); idle();
        push("bypass_stored", 0, 32'h3);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
    endtask

    task automatic test_port_priority();
        step(); idle();
        RFwrite = 2'b11; RegW[0] = 5'd6; RegW[1] = 5'd6;
        dataW[0] = 32'h7; dataW[1] = 32'h9; RegR[1] = 5'd6;
        push("prio_bypass", 1, 32'h9);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        step(); idle();
        push("prio_stored", 1, 32'h9); push("prio_r2_kept", 0, 32'h3);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
    endtask

    task automatic test_zero_reg();
        step(); idle();
        RFwrite[1] = 1'b1; RegW[1] = 5'd0; dataW[1] = 32'hB; RegR[0] = 5'd0;
        push("r0_no_bypass", 0, 32'h0);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        step(); idle();
        issue = 1'b1; issueReg = 5'd0;
        push("r0_read", 0, 32'h0); push("r0_issueReady", 4, 32'h1);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        step(); idle();
        push("r0_anyPending", 5, 32'h0); push("r0_busyR0", 2, 32'h0);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
    endtask

    task automatic test_pending();
        step(); idle();
        issue = 1'b1; issueReg = 5'd7; RegR[0] = 5'd7;
        push("pend_first_ready", 4, 32'h1); push("pend_first_any", 5, 32'h0);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        step();
        push("pend_reissue_ready", 4, 32'h0); push("pend_busy", 2, 32'h1);
        push("pend_any", 5, 32'h1);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        step();
        RFwrite[0] = 1'b1; RegW[0] = 5'd7; dataW[0] = 32'h55;
        push("wb_issue_ready", 4, 32'h1); push("wb_busy_masked", 2, 32'h0);
        push("wb_bypass", 0, 32'h55);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        step(); idle(); issueReg = 5'd7;
        push("wb_reissue_busy", 2, 32'h1); push("wb_reissue_any", 5, 32'h1);
        push("wb_reissue_blocked", 4, 32'h0); push("wb_stored", 0, 32'h55);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        RFwrite[0] = 1'b1; RegW[0] = 5'd7; dataW[0] = 32'h56;
        step(); idle();
        push("wb_clear_busy", 2, 32'h0); push("wb_clear_any", 5, 32'h0);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
    endtask

    task automatic test_flush();
        step(); idle(); issue = 1'b1; issueReg = 5'd1;
        step(); issueReg = 5'd3;
        step(); idle();
        flush = 1'b1; issue = 1'b1; issueReg = 5'd5; RegR[0] = 5'd1; RegR[1] = 5'd3;
        RFwrite[0] = 1'b1; RegW[0] = 5'd9; dataW[0] = 32'h99;
        push("flush_ready", 4, 32'h0); push("flush_busy1", 2, 32'h1);
        push("flush_busy3", 3, 32'h1); push("flush_any_before", 5, 32'h1);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
        step(); idle(); issueReg = 5'd5; RegR[0] = 5'd9; RegR[1] = 5'd6;
        push("flush_any_after", 5, 32'h0); push("flush_r5_free", 4, 32'h1);
        push("flush_write_commit", 0, 32'h99); push("flush_r6_kept", 1, 32'h9);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
    endtask

    task automatic test_reset_override();
        step(); idle();
        reset = 1'b0; RFwrite[0] = 1'b1; RegW[0] = 5'd1; dataW[0] = 32'h1;
        issue = 1'b1; issueReg = 5'd4;
        step(); idle(); RegR[0] = 5'd1; RegR[1] = 5'd2;
        push("rstov_r1", 0, 32'h0); push("rstov_r2", 1, 32'h0);
        push("rstov_any", 5, 32'h0);
        #2;
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); act = observe(e.sel); total++;
            if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) model[r] = 32'h0;
        for (int n = 0; n < 40; n++) begin
            step(); idle();
            for (int p = 0; p < 2; p++) begin
                RFwrite[p] = 1'($urandom_range(0, 1));
                RegW[p]    = 5'($urandom_range(0, 7));
                dataW[p]   = $urandom;
                RegR[p]    = 5'($urandom_range(0, 7));
            end
            for (int k = 0; k < 2; k++) begin
                v = model[RegR[k]];
                if (RFwrite[0] && RegW[0] == RegR[k]) v = dataW[0];
                if (RFwrite[1] && RegW[1] == RegR[k]) v = dataW[1];
                if (RegR[k] == 5'd0) v = 32'h0;
                push($sformatf("b2b_data%0d_c%0d", k, n), k, v);
            end
            push($sformatf("b2b_busy_c%0d", n), 2, 32'h0);
            #2;
            while (expQ.size() > 0) begin
                e = expQ.pop_front(); act = observe(e.sel); total++;
                if (act !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.val); end
            end
            for (int p = 0; p < 2; p++) begin
                if (RFwrite[p] && RegW[p] != 5'd0) model[RegW[p]] = dataW[p];
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_port_priority();
        test_zero_reg();
        test_pending();
        test_flush();
        test_reset_override();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
